evm_result_reader: RTL

//  Result-readout initiator for the EVM core (EVM_v3). It is the other end of the core's mode/candid_button ->

---
 rtl/evm_result_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/evm_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : evm_result_reader
// Purpose  : Drives the EVM core into result mode, reads each candidate tally
//            and reports the winner and any tie on the maximum.
// Revision : 1.0
// ============================================================================
module evm_result_reader #(
  parameter int NUM_CAND      = 4,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic                        evm_mode,
  output logic [NUM_CAND-1:0]         evm_candid_button,
  input  logic [CNT_W-1:0]            display_out,
  output logic [NUM_CAND*CNT_W-1:0]   tally_flat,
  output logic [$clog2(NUM_CAND)-1:0] winner,
  output logic                        tie,
  output logic                        busy,
  output logic                        done,
  output logic                        results_valid
);

  localparam int c_IDX_W    = $clog2(NUM_CAND);
  localparam int c_MAX_HOLD = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int c_TMR_W    = $clog2(c_MAX_HOLD + 1);
  localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LAST    = c_TMR_W'(GAP_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST    = c_IDX_W'(NUM_CAND - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MODE_SETUP = 3'd1,
    S_SELECT     = 3'd2,
    S_GAP        = 3'd3,
    S_EVAL       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_IDX_W-1:0] r_idx;
  logic [CNT_W-1:0]   r_tally [NUM_CAND];
  logic [c_IDX_W-1:0] r_winner;
  logic               r_tie;
  logic               r_results_valid;
  logic               w_accept;
  logic               w_capture;
  logic [CNT_W-1:0]   w_max;
  logic [c_IDX_W-1:0] w_win;
  logic               w_tie;

  assign w_accept  = (r_state == S_IDLE) && start && !abort;
  assign w_capture = (r_state == S_SELECT) && (r_tmr == c_SETTLE_LAST) && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    evm_mode          = 1'b0;
    evm_candid_button = '0;
    busy              = 1'b1;
    done              = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_next = S_MODE_SETUP;
      end
      S_MODE_SETUP: begin
        evm_mode = 1'b1;
        if (r_tmr == c_GAP_LAST) w_state_next = S_SELECT;
      end
      S_SELECT: begin
        evm_mode          = 1'b1;
        evm_candid_button = NUM_CAND'(1) << r_idx;
        if (r_tmr == c_SETTLE_LAST) w_state_next = S_GAP;
      end
      S_GAP: begin
        evm_mode = 1'b1;
        if (r_tmr == c_GAP_LAST)
          w_state_next = (r_idx == c_IDX_LAST) ? S_EVAL : S_SELECT;
      end
      S_EVAL: begin
        evm_mode     = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        evm_mode     = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && abort) w_state_next = S_IDLE;
  end

  // Every state change restarts the hold timer, so one counter serves all phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmr <= '0;
      r_idx <= '0;
    end else begin
      if (r_state == S_IDLE || w_state_next != r_state) r_tmr <= '0;
      else                                              r_tmr <= r_tmr + 1'b1;
      if (r_state == S_IDLE)                                   r_idx <= '0;
      else if (r_state == S_GAP && w_state_next == S_SELECT)   r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_max = r_tally[0];
    w_win = '0;
    w_tie = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (r_tally[i] > w_max) begin
        w_max = r_tally[i];
        w_win = c_IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (r_tally[i] == w_max && c_IDX_W'(i) != w_win) w_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
      r_winner        <= '0;
      r_tie           <= 1'b0;
      r_results_valid <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
      r_winner        <= '0;
      r_tie           <= 1'b0;
      r_results_valid <= 1'b0;
    end else begin
      if (w_capture) r_tally[r_idx] <= display_out;
      if (r_state == S_EVAL && !abort) begin
        r_winner        <= w_win;
        r_tie           <= w_tie;
        r_results_valid <= 1'b1;
      end
      if (abort) r_results_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_flat
    assign tally_flat[g*CNT_W +: CNT_W] = r_tally[g];
  end

  assign winner        = r_winner;
  assign tie           = r_tie;
  assign results_valid = r_results_valid;

endmodule
`default_nettype wire
